// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped instruction cache. It answers fetch-line requests
//            from the instruction fetch queue. Each request returns a 128-bit
//            line of four instructions. A miss refills the line over a 32-bit
//            memory port in four beats, word 0 first.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1    clock, all state changes on posedge
//   reset       in   1    asynchronous active-low reset
//   Pc_in       in   32   fetch word address (bits [1:0] ignored)
//   Rd_en       in   1    fetch request from the queue
//   Abort       in   1    redirect, cancels an outstanding request
//   Dout        out  128  line data, word i on bits [32i+31:32i]
//   Dout_valid  out  1    Dout holds the line addressed by Pc_in
//   Mem_req     out  1    refill request
//   Mem_addr    out  32   refill word address {miss_line, 2'b00}
//   Mem_gnt     in   1    memory accepted the request
//   Mem_rdata   in   32   refill beat data
//   Mem_rvalid  in   1    refill beat valid
//   Hit_count   out  32   (ICACHE_PERF_EN only) saturating hit counter
//   Miss_count  out  32   (ICACHE_PERF_EN only) saturating miss counter
// Build option: define ICACHE_PERF_EN to add the hit/miss counters.
// ============================================================================
module icache #(
  parameter int IDX_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  Pc_in,
  input  logic         Rd_en,
  input  logic         Abort,
  output logic [127:0] Dout,
  output logic         Dout_valid,
  output logic         Mem_req,
  output logic [31:0]  Mem_addr,
  input  logic         Mem_gnt,
  input  logic [31:0]  Mem_rdata,
  input  logic         Mem_rvalid
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]  Hit_count,
  output logic [31:0]  Miss_count
`endif
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [29:0]        miss_line_q, miss_line_d;
  logic [1:0]         beat_q, beat_d;
  logic [127:0]       fill_q, fill_d;
  logic               mem_req_q, mem_req_d;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];

  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               hit;
  logic [IDX_W-1:0]   miss_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic               install;
  logic [127:0]       install_line;
  logic               unused_pc_lo;

  // Instruction-word granular: the byte offset never takes part in lookup.
  assign unused_pc_lo = ^Pc_in[1:0];

  assign lk_idx   = Pc_in[IDX_W+1:2];
  assign lk_tag   = Pc_in[31:IDX_W+2];
  assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // Install location comes only from the latched miss line, so Pc_in may
  // wander freely while the refill is in flight.
  assign miss_idx = miss_line_q[IDX_W-1:0];
  assign miss_tag = miss_line_q[29:IDX_W];

  assign Dout_valid = (state_q == S_IDLE) && Rd_en && hit && !Abort;
  assign Dout       = Dout_valid ? data_q[lk_idx] : 128'h0;
  assign Mem_req    = mem_req_q;
  assign Mem_addr   = {miss_line_q, 2'b00};

  always_comb begin
    state_d      = state_q;
    miss_line_d  = miss_line_q;
    beat_d       = beat_q;
    fill_d       = fill_q;
    mem_req_d    = mem_req_q;
    install      = 1'b0;
    // The last beat bypasses the fill buffer so the line installs on the
    // same edge that accepts it.
    install_line = {Mem_rdata, fill_q[95:0]};

    case (state_q)
      S_IDLE: begin
        if (Rd_en && !hit && !Abort) begin
          miss_line_d = Pc_in[31:2];
          mem_req_d   = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // Grant takes priority over a same-cycle abort: once memory has
        // accepted, the beats are coming regardless.
        if (Mem_gnt) begin
          mem_req_d = 1'b0;
          beat_d    = 2'd0;
          state_d   = S_FILL;
        end else if (Abort) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_FILL: begin
        if (Mem_rvalid) begin
          fill_d[{beat_q, 5'd0} +: 32] = Mem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            install = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      miss_line_q <= '0;
      beat_q      <= '0;
      fill_q      <= '0;
      mem_req_q   <= 1'b0;
      valid_q     <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      beat_q      <= beat_d;
      fill_q      <= fill_d;
      mem_req_q   <= mem_req_d;
      if (install) begin
        valid_q[miss_idx] <= 1'b1;
        tag_q[miss_idx]   <= miss_tag;
        data_q[miss_idx]  <= install_line;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (Dout_valid && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if ((state_q == S_IDLE) && (state_d == S_REQ) &&
        (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign Hit_count  = hit_count_q;
  assign Miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache; the responder on the fetch-line interface consumed by the instruction fetch queue.
- Accepts a word-granular fetch PC plus a read request, and returns a 128-bit line (four instructions) with a valid strobe.
- On a miss, refills the line from a 32-bit memory port in four beats.
- Sits between the fetch queue and the instruction memory/bus.

Parameters:
- IDX_W, 4, index width; line count = 2**IDX_W.
- TAG_W, 30-IDX_W, tag width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- Pc_in  in  32  fetch word address; line address = Pc_in[31:2], bits [1:0] ignored.
- Rd_en  in  1  fetch request from the queue (queue not full).
- Abort  in  1  jump/branch redirect; cancels an outstanding request.
- Dout  out  128  line data; word i on bits [32i+31:32i].
- Dout_valid  out  1  Dout holds the line for the current Pc_in.
- Mem_req  out  1  refill request to memory.
- Mem_addr  out  32  refill word address, always {line_addr, 2'b00}.
- Mem_gnt  in  1  memory accepted the request.
- Mem_rdata  in  32  refill beat data.
- Mem_rvalid  in  1  beat valid; beats arrive in order, word 0 first.

Behaviour:
- Reset values (asynchronous):
  - all valid bits = 0, tag and data arrays = 0.
  - state = IDLE, beat counter = 0, miss line register = 0.
  - Mem_req = 0, Mem_addr = 0, Dout_valid = 0, Dout = 0.
- Lookup:
  - index = Pc_in[IDX_W+1:2]; tag = Pc_in[31:IDX_W+2].
  - hit = valid[index] & (tag_array[index] == tag).
  - Lookup is combinational, with zero latency.
- Dout_valid = (state==IDLE) & Rd_en & hit & !Abort.
- Dout = data_array[index] when Dout_valid is 1, otherwise 128'h0.
- The queue advances Pc_in on the edge where Dout_valid=1, so back-to-back hits deliver one line per cycle.
- IDLE:
  - On Rd_en & !hit & !Abort: latch miss_line = Pc_in[31:2] and go to REQ.
  - On Abort: stay in IDLE, no miss is started.
- REQ:
  - Mem_req=1 and Mem_addr={miss_line,2'b00}, both held stable until Mem_gnt.
  - On Abort & !Mem_gnt (same cycle): drop Mem_req and go to IDLE; no memory transaction occurs.
  - On Mem_gnt: deassert Mem_req next cycle, clear beat counter, go to FILL. Abort in the grant cycle is ignored because the grant wins.
- FILL:
  - Each Mem_rvalid writes Mem_rdata into a 128-bit fill buffer word [beat] and increments beat (2-bit).
  - On the beat==3 write:
    - data_array[miss_idx] = completed line (fill buffer plus the final beat).
    - tag_array = miss tag; valid = 1.
    - go to IDLE.
  - Abort during FILL is ignored: the line is completed and installed, since memory beats are already in flight.
  - Dout_valid = 0 throughout REQ and FILL.
- Refill-to-hit latency: the first cycle back in IDLE gives a hit if Pc_in still addresses miss_line.
- The miss address is taken only from miss_line. Pc_in changes during REQ/FILL do not affect Mem_addr or the install index.
- Mem_rvalid outside FILL is ignored.
- Aliasing lines (same index, different tag) replace each other; no invalidate port.
- reset asserted mid-refill: immediate return to IDLE, all lines invalid, Mem_req=0. A partial fill is discarded.

Optional Feature:
- Macro ICACHE_PERF_EN.
- When defined:
  - Adds outputs Hit_count[31:0] and Miss_count[31:0], both reset to 0.
  - Hit_count increments on each cycle with Dout_valid=1.
  - Miss_count increments on each IDLE->REQ transition.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, Pc_in=32'h0000_0010, Rd_en=1.
  - Expect Mem_req=1 with Mem_addr=32'h10.
  - Return gnt, then beats 11,22,33,44.
  - Next IDLE cycle: Dout_valid=1, Dout=128'h00000044_00000033_00000022_00000011.
- Streaming hits: preload lines 0x10 and 0x14; Pc_in steps 0x10 -> 0x14 on consecutive cycles -> Dout_valid=1 both cycles, no Mem_req.
- Conflict: fill Pc_in=0x10, then Pc_in=0x50 (same index, IDX_W=4) -> miss and refill. Re-request 0x10 -> miss again.
- Abort in REQ: hold Mem_gnt=0, assert Abort one cycle -> Mem_req=0 next cycle, state IDLE, no beats expected.
- Abort in FILL: Abort after beat 1 -> all 4 beats still accepted, line installed, later hit returns full data.
- Reset mid-fill: drive reset=0 after beat 2 -> Mem_req=0 and Dout_valid=0. Re-request the same line -> miss (valid cleared).
- With ICACHE_PERF_EN: after the cold-miss scenario, Miss_count=1 and Hit_count=1.
